// File: rtl/ib_mul_8x8_qs_mac.sv
// rtl/ib_mul_8x8_qs_mac.sv - operand FIFO, quarter-squares multiplier sequencer and dot-product accumulator
module ib_mul_8x8_qs_mac #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ACC_W = 24
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [7:0]       i_in_a,
    input  logic [7:0]       i_in_b,
    input  logic             i_in_last,
    output logic             o_mul_start,
    output logic [7:0]       o_mul_a,
    output logic [7:0]       o_mul_b,
    input  logic [15:0]      i_mul_c,
    input  logic             i_mul_done,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [ACC_W-1:0] o_out_acc,
    output logic [8:0]       o_out_count,
    output logic             o_out_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SQ,
        S_DIFF,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic [16:0]      mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full, empty, push, pop;
    logic             last_q;
    logic [ACC_W-1:0] acc_q;
    logic [8:0]       cnt_q;
    logic             ovf_q;
    logic [ACC_W:0]   sum;
    logic             capture, clear;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = i_in_valid && !full;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {i_in_last, i_in_a, i_in_b};
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_SQ;
                end
            end
            S_SQ: state_d = S_DIFF;
            S_DIFF: begin
                if (i_mul_done) begin
                    if (last_q) begin
                        state_d = S_OUT;
                    end else if (!empty) begin
                        pop     = 1'b1;
                        state_d = S_SQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_OUT: begin
                if (i_out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign capture = (state_q == S_DIFF) && i_mul_done;
    assign clear   = (state_q == S_OUT) && i_out_ready;
    assign sum     = {1'b0, acc_q} + (ACC_W+1)'(i_mul_c);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= S_IDLE;
            o_mul_a <= '0;
            o_mul_b <= '0;
            last_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                {last_q, o_mul_a, o_mul_b} <= mem[rd_ptr[AW-1:0]];
            end
            if (capture) begin
                acc_q <= sum[ACC_W-1:0];
                ovf_q <= ovf_q | sum[ACC_W];
                if (cnt_q != 9'd511) begin
                    cnt_q <= cnt_q + 9'd1;
                end
            end else if (clear) begin
                acc_q <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end
        end
    end

    assign o_in_ready  = !full;
    assign o_mul_start = (state_q == S_SQ);
    assign o_out_valid = (state_q == S_OUT);
    assign o_out_acc   = acc_q;
    assign o_out_count = cnt_q;
    assign o_out_ovf   = ovf_q;

endmodule

// File: tb/tb_ib_mul_8x8_qs_mac.sv
// tb/tb_ib_mul_8x8_qs_mac.sv - directed self-checking bench for ib_mul_8x8_qs_mac
module tb_ib_mul_8x8_qs_mac;

    logic        i_clk = 1'b0;
    logic        i_nrst = 1'b0;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic [7:0]  i_in_a = '0;
    logic [7:0]  i_in_b = '0;
    logic        i_in_last = 1'b0;
    logic        o_mul_start;
    logic [7:0]  o_mul_a, o_mul_b;
    logic [15:0] i_mul_c;
    logic        i_mul_done;
    logic        o_out_valid;
    logic        i_out_ready = 1'b1;
    logic [23:0] o_out_acc;
    logic [8:0]  o_out_count;
    logic        o_out_ovf;

    int n_checks = 0;
    int n_fail = 0;
    int stall = 0;
    int wcnt = 0;
    int start_cnt = 0;

    ib_mul_8x8_qs_mac #(.DEPTH(4), .ACC_W(24)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_a(i_in_a), .i_in_b(i_in_b), .i_in_last(i_in_last),
        .o_mul_start(o_mul_start), .o_mul_a(o_mul_a), .o_mul_b(o_mul_b),
        .i_mul_c(i_mul_c), .i_mul_done(i_mul_done),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_acc(o_out_acc), .o_out_count(o_out_count), .o_out_ovf(o_out_ovf)
    );

    always #5 i_clk = ~i_clk;

    // Multiplier stand-in: done arrives 1 + stall cycles after the start pulse.
    always @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            i_mul_done <= 1'b0;
            i_mul_c    <= '0;
            wcnt       <= 0;
        end else if (o_mul_start) begin
            i_mul_c    <= 16'(o_mul_a) * 16'(o_mul_b);
            wcnt       <= stall;
            i_mul_done <= (stall == 0);
        end else if (wcnt != 0) begin
            wcnt       <= wcnt - 1;
            i_mul_done <= (wcnt == 1);
        end else begin
            i_mul_done <= 1'b0;
        end
    end

    always @(posedge i_clk) begin
        if (o_mul_start) start_cnt <= start_cnt + 1;
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic last);
        int n;
        i_in_valid = 1'b1;
        i_in_a = a;
        i_in_b = b;
        i_in_last = last;
        n = 0;
        while (!o_in_ready && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        @(negedge i_clk);
        i_in_valid = 1'b0;
        i_in_last = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        int n;
        n = 0;
        while (!o_out_valid && n < limit) begin
            @(negedge i_clk);
            n++;
        end
        n_checks++;
        if (!o_out_valid) begin
            n_fail++;
            $display("FAIL wait_valid: o_out_valid=%0b after %0d cycles, required 1", o_out_valid, n);
        end
    endtask

    task automatic check_result(input string name, input logic [23:0] acc, input logic [8:0] cnt, input logic ovf);
        n_checks++;
        if (o_out_acc !== acc || o_out_count !== cnt || o_out_ovf !== ovf) begin
            n_fail++;
            $display("FAIL %s: acc=%0d count=%0d ovf=%0b, required acc=%0d count=%0d ovf=%0b",
                     name, o_out_acc, o_out_count, o_out_ovf, acc, cnt, ovf);
        end
    endtask

    task automatic finish_handshake();
        i_out_ready = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if (o_out_valid !== 1'b0 || o_out_acc !== 24'd0 || o_out_count !== 9'd0) begin
            n_fail++;
            $display("FAIL post_handshake: valid=%0b acc=%0d count=%0d, required 0 0 0",
                     o_out_valid, o_out_acc, o_out_count);
        end
        @(negedge i_clk);
    endtask

    task automatic check_reset_values(input string name);
        n_checks++;
        if (o_in_ready !== 1'b1 || o_mul_start !== 1'b0 || o_mul_a !== 8'd0 || o_mul_b !== 8'd0 ||
            o_out_valid !== 1'b0 || o_out_acc !== 24'd0 || o_out_count !== 9'd0 || o_out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: rdy=%0b start=%0b a=%0d b=%0d valid=%0b acc=%0d cnt=%0d ovf=%0b, required 1 0 0 0 0 0 0 0",
                     name, o_in_ready, o_mul_start, o_mul_a, o_mul_b, o_out_valid, o_out_acc, o_out_count, o_out_ovf);
        end
    endtask

    task automatic test_reset();
        i_nrst = 1'b0;
        repeat (2) @(negedge i_clk);
        check_reset_values("reset_state");
        i_nrst = 1'b1;
        @(negedge i_clk);
        check_reset_values("after_release");
    endtask

    task automatic test_single();
        i_out_ready = 1'b1;
        push(8'd3, 8'd5, 1'b1);
        n_checks++;
        if (o_mul_start !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c1_start: start=%0b, required 0", o_mul_start);
        end
        @(negedge i_clk);
        n_checks++;
        if (o_mul_start !== 1'b1 || o_mul_a !== 8'd3 || o_mul_b !== 8'd5) begin
            n_fail++;
            $display("FAIL single_c2_start: start=%0b a=%0d b=%0d, required 1 3 5", o_mul_start, o_mul_a, o_mul_b);
        end
        @(negedge i_clk);
        n_checks++;
        if (o_mul_start !== 1'b0 || o_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_c3: start=%0b valid=%0b, required 0 0", o_mul_start, o_out_valid);
        end
        @(negedge i_clk);
        n_checks++;
        if (o_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_c4_valid: valid=%0b, required 1", o_out_valid);
        end
        check_result("single_result", 24'd15, 9'd1, 1'b0);
        finish_handshake();
    endtask

    task automatic test_back_to_back();
        int last_start;
        int nst;
        logic prev_start;
        logic [7:0] sa, sb;
        i_out_ready = 1'b1;
        nst = 0;
        last_start = 0;
        prev_start = 1'b0;
        sa = '0;
        sb = '0;
        fork
            begin
                for (int i = 0; i < 4; i++) push(8'd255, 8'd255, i == 3);
            end
            begin
                for (int cyc = 1; cyc < 60 && !o_out_valid; cyc++) begin
                    @(negedge i_clk);
                    if (prev_start) begin
                        n_checks++;
                        if (o_mul_start !== 1'b0 || o_mul_a !== sa || o_mul_b !== sb) begin
                            n_fail++;
                            $display("FAIL b2b_hold: start=%0b a=%0d b=%0d, required 0 %0d %0d",
                                     o_mul_start, o_mul_a, o_mul_b, sa, sb);
                        end
                    end
                    if (o_mul_start) begin
                        if (nst > 0) begin
                            n_checks++;
                            if (cyc - last_start != 2) begin
                                n_fail++;
                                $display("FAIL b2b_gap: gap=%0d, required 2", cyc - last_start);
                            end
                        end
                        last_start = cyc;
                        nst++;
                        sa = o_mul_a;
                        sb = o_mul_b;
                    end
                    prev_start = o_mul_start;
                end
            end
        join
        n_checks++;
        if (nst != 4) begin
            n_fail++;
            $display("FAIL b2b_starts: starts=%0d, required 4", nst);
        end
        wait_valid(20);
        check_result("b2b_result", 24'd260100, 9'd4, 1'b0);
        finish_handshake();
    endtask

    task automatic test_backpressure();
        i_out_ready = 1'b0;
        push(8'd1, 8'd2, 1'b0);
        push(8'd3, 8'd4, 1'b1);
        wait_valid(40);
        check_result("bp_first", 24'd14, 9'd2, 1'b0);
        push(8'd1, 8'd1, 1'b0);
        push(8'd2, 8'd2, 1'b0);
        push(8'd3, 8'd3, 1'b0);
        n_checks++;
        if (o_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_3: in_ready=%0b, required 1", o_in_ready);
        end
        push(8'd4, 8'd4, 1'b1);
        n_checks++;
        if (o_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_full: in_ready=%0b, required 0", o_in_ready);
        end
        repeat (3) @(negedge i_clk);
        n_checks++;
        if (o_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold_valid: valid=%0b, required 1", o_out_valid);
        end
        check_result("bp_hold", 24'd14, 9'd2, 1'b0);
        i_out_ready = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if (o_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drop: valid=%0b, required 0", o_out_valid);
        end
        wait_valid(40);
        check_result("bp_second", 24'd30, 9'd4, 1'b0);
        finish_handshake();
    endtask

    task automatic test_overflow();
        i_out_ready = 1'b1;
        for (int i = 0; i < 259; i++) push(8'd255, 8'd255, i == 258);
        wait_valid(200);
        check_result("ovf_result", 24'd64259, 9'd259, 1'b1);
        finish_handshake();
    endtask

    task automatic test_reset_mid_run();
        int base;
        int n;
        i_out_ready = 1'b1;
        base = start_cnt;
        push(8'd2, 8'd3, 1'b0);
        push(8'd4, 8'd5, 1'b0);
        push(8'd6, 8'd7, 1'b1);
        n = 0;
        while (start_cnt < base + 2 && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        n_checks++;
        if (start_cnt != base + 2 || o_mul_a !== 8'd4) begin
            n_fail++;
            $display("FAIL rst_reach_diff: starts=%0d a=%0d, required %0d 4", start_cnt - base, o_mul_a, 2);
        end
        i_nrst = 1'b0;
        #1;
        check_reset_values("rst_mid_async");
        @(negedge i_clk);
        check_reset_values("rst_mid_held");
        i_nrst = 1'b1;
        @(negedge i_clk);
        check_reset_values("rst_mid_release");
        push(8'd2, 8'd7, 1'b1);
        wait_valid(20);
        check_result("rst_new_run", 24'd14, 9'd1, 1'b0);
        finish_handshake();
    endtask

    task automatic test_stalled_done();
        i_out_ready = 1'b1;
        stall = 3;
        push(8'd4, 8'd6, 1'b0);
        push(8'd5, 8'd5, 1'b1);
        n_checks++;
        if (o_mul_start !== 1'b1 || o_mul_a !== 8'd4 || o_mul_b !== 8'd6) begin
            n_fail++;
            $display("FAIL stall_start: start=%0b a=%0d b=%0d, required 1 4 6", o_mul_start, o_mul_a, o_mul_b);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            n_checks++;
            if (o_mul_start !== 1'b0 || o_mul_a !== 8'd4 || o_mul_b !== 8'd6 || i_mul_done !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: cycle=%0d start=%0b a=%0d b=%0d done=%0b, required 0 4 6 0",
                         i, o_mul_start, o_mul_a, o_mul_b, i_mul_done);
            end
        end
        wait_valid(40);
        check_result("stall_result", 24'd49, 9'd2, 1'b0);
        stall = 0;
        finish_handshake();
    endtask

    initial begin
        @(negedge i_clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_mid_run();
        test_stalled_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ib_mul_8x8_qs_mac.md
# ib_mul_8x8_qs_mac

Dot-product sequencer that sits on both sides of the 8x8 quarter-squares multiplier. It buffers incoming operand pairs, holds each pair stable for the multiplier's two-cycle sum-square/difference-square window, and issues the start pulse. It captures each finished 16-bit product, accumulates a run of products terminated by a `last` flag, and presents the sum on a valid/ready output.

## Interface
- `DEPTH`, 4, operand FIFO entries; power of two, at least 2
- `ACC_W`, 24, accumulator width; minimum 16
- `i_clk` in 1: clock, rising edge
- `i_nrst` in 1: reset, asynchronous, active-low
- `i_in_valid` in 1: operand pair offered
- `o_in_ready` out 1: FIFO not full
- `i_in_a` in 8: operand A
- `i_in_b` in 8: operand B
- `i_in_last` in 1: pair closes the current dot product
- `o_mul_start` out 1: multiplier start pulse
- `o_mul_a` out 8: multiplier operand A, registered
- `o_mul_b` out 8: multiplier operand B, registered
- `i_mul_c` in 16: multiplier result, valid while `i_mul_done`=1
- `i_mul_done` in 1: multiplier completion
- `o_out_valid` out 1: result available
- `i_out_ready` in 1: result consumed
- `o_out_acc` out ACC_W: sum of products, modulo 2^ACC_W
- `o_out_count` out 9: number of products in the run, saturating at 511
- `o_out_ovf` out 1: accumulator carried out at least once during the run

## Operation
- FIFO entry is {last, a, b}.
  - Push when `i_in_valid & o_in_ready`.
  - `o_in_ready = !full` is registered-state based. A pop in the same cycle does not admit a push while full.
- FSM states: IDLE, SQ, DIFF, OUT.
- IDLE: if the FIFO is non-empty, pop into `o_mul_a`/`o_mul_b`/last register and go to SQ.
- SQ: `o_mul_start`=1 and operands held. Next state is DIFF.
- DIFF: `o_mul_start`=0 and operands still held.
  - While `i_mul_done`=0, stay in DIFF.
  - On `i_mul_done`=1: add `i_mul_c`, zero-extended, to the accumulator.
    - Increment the count, saturating.
    - Set the ovf flag if the add carries out of ACC_W.
  - Then:
    - If last is set, go to OUT.
    - Else, if the FIFO is non-empty, pop and go to SQ.
    - Else go to IDLE, keeping the accumulator.
- OUT: `o_out_valid`=1. `o_out_acc`/`o_out_count`/`o_out_ovf` are stable while valid.
  - On `i_out_ready`, clear the accumulator, count and ovf, then go to IDLE.
  - The FIFO keeps accepting pushes while in OUT.
- Operands never change and `o_mul_start` never asserts outside SQ. A start is never issued in the cycle after another start.
- Zero operands are legal. The product is 0 and the count still increments.

## Timing
- Reset values:
  - state IDLE, FIFO empty
  - `o_in_ready`=1, `o_mul_start`=0, `o_mul_a`=`o_mul_b`=0
  - `o_out_valid`=0, `o_out_acc`=0, `o_out_count`=0, `o_out_ovf`=0
- Reset asserted mid-run discards the FIFO contents, the partial sum and any in-flight product. The first cycle after release is IDLE.
- Single pair accepted in cycle 0 into an empty FIFO while IDLE:
  - pop at the end of cycle 1
  - `o_mul_start`=1 in cycle 2
  - capture in cycle 3
  - `o_out_valid`=1 in cycle 4
- Back-to-back products: DIFF→SQ directly, giving one product every 2 cycles.
- `o_out_valid` drops the cycle after a handshake. With the next run already buffered, the next SQ follows at the earliest 2 cycles after the handshake (OUT→IDLE→SQ).

## Test plan
- **Single product:** a=3, b=5, last=1 in cycle 0.
  - Required: start in cycle 2, valid in cycle 4, acc=15, count=1, ovf=0.
- **Four pairs of 255×255, last on the 4th, `i_out_ready`=1:**
  - Required: acc=260100, count=4.
  - Required: starts exactly 2 cycles apart; operands stable across each SQ/DIFF pair.
- **Backpressure:** `i_out_ready`=0, two runs pushed continuously.
  - Required: the output holds the first run's values.
  - Required: `o_in_ready` falls after DEPTH further pushes.
  - Required: after ready=1, the second run's result appears correctly.
- **Overflow:** 259 pairs of 255×255, last on the 259th.
  - Required: acc=64259, count=259, ovf=1.
- **Reset mid-run:** assert `i_nrst`=0 during DIFF of the 2nd of 3 pairs.
  - Required: all outputs at reset values.
  - Required: a new single pair 2×7 afterwards yields acc=14, count=1.
- **Stalled done:** hold `i_mul_done`=0 for 3 cycles in DIFF.
  - Required: operands held, no new start, sum correct once done arrives.
